// File: rtl/chip_test_sequencer_if.sv
// -----------------------------------------------------------------------------
// chip_test_sequencer_if
// Handshake bundle between the test sequencer and the chip checker.
//   Chk_Run       : sequencer -> checker, start a check (1-cycle pulse)
//   Chk_DISP_RSLT : sequencer -> checker, checker may present its result
//   Chk_Done      : checker -> sequencer, check finished
//   Chk_RSLT      : checker -> sequencer, 1 = pass, valid while Chk_Done is high
// master modport is the sequencer side, slave modport is the checker side.
// -----------------------------------------------------------------------------
interface chip_test_sequencer_if;
  logic Chk_Run;
  logic Chk_DISP_RSLT;
  logic Chk_Done;
  logic Chk_RSLT;

  modport master (
    output Chk_Run,
    output Chk_DISP_RSLT,
    input  Chk_Done,
    input  Chk_RSLT
  );

  modport slave (
    input  Chk_Run,
    input  Chk_DISP_RSLT,
    output Chk_Done,
    output Chk_RSLT
  );
endinterface

// File: rtl/chip_test_sequencer.sv
// -----------------------------------------------------------------------------
// chip_test_sequencer
// Push-button driven sequencer for an external chip checker. A synchronized
// rising edge on Start launches one check run, waits for the checker (with a
// hang timeout), latches the verdict onto three LEDs and holds the result for
// a minimum display time before accepting another Start.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before the checker is declared hung (2..65535)
//   HOLD_CYCLES    : minimum SHOW duration before returning to IDLE (1..65535)
// Ports
//   Clk, Reset_n   : single clock, asynchronous active-low reset
//   Start          : asynchronous push-button level, active high
//   chk            : checker handshake (Run / DISP_RSLT out, Done / RSLT in)
//   Busy           : high whenever the sequencer is not in IDLE
//   Pass_LED, Fail_LED, Timeout_LED : latched verdict of the last run
//   Pass_Count, Fail_Count          : saturating tallies (CHIP_TALLY_EN only)
// Optional feature macro: CHIP_TALLY_EN (adds the two 8-bit tally counters).
// -----------------------------------------------------------------------------
module chip_test_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  chip_test_sequencer_if.master chk,
  output logic                  Busy,
  output logic                  Pass_LED,
  output logic                  Fail_LED,
  output logic                  Timeout_LED
`ifdef CHIP_TALLY_EN
  ,
  output logic [7:0]            Pass_Count,
  output logic [7:0]            Fail_Count
`endif
);

  localparam int MAX_CYC = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_SHOW    = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_next_s;

  logic       start_meta_r;
  logic       start_sync_r;
  logic       start_prev_r;
  logic [1:0] sync_vld_r;
  logic       start_edge_s;

  logic chk_run_r;
  logic chk_disp_r;
  logic busy_r;
  logic pass_led_r;
  logic fail_led_r;
  logic timeout_led_r;

  // Saturating 8-bit increment for the tally counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      sat_inc8 = cnt;
    end else begin
      sat_inc8 = cnt + 8'd1;
    end
  endfunction

  // Start synchronizer and edge history. The history flop is forced high until
  // the synchronizer has refilled after reset, so a button already held down
  // at reset release is never mistaken for a fresh press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b1;
      sync_vld_r   <= 2'b00;
    end else begin
      start_meta_r <= Start;
      start_sync_r <= start_meta_r;
      sync_vld_r   <= {sync_vld_r[0], 1'b1};
      start_prev_r <= sync_vld_r[1] ? start_sync_r : 1'b1;
    end
  end

  assign start_edge_s = start_sync_r & ~start_prev_r;

  // State and timer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      timer_r <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
    end
  end

  // Next-state and timer logic. The timer is cleared on every exit from WAIT
  // and SHOW, so it never counts past its terminal value.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    case (state_r)
      ST_IDLE: begin
        timer_next_s = {TMR_W{1'b0}};
        if (start_edge_s) begin
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        timer_next_s = {TMR_W{1'b0}};
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is tested first so it wins a tie with the timeout.
        if (chk.Chk_Done) begin
          state_next_s = ST_CAPTURE;
          timer_next_s = {TMR_W{1'b0}};
        end else if (timer_r == TMO_LAST) begin
          state_next_s = ST_TIMEOUT;
          timer_next_s = {TMR_W{1'b0}};
        end else begin
          state_next_s = ST_WAIT;
          timer_next_s = timer_r + 1'b1;
        end
      end
      ST_CAPTURE: begin
        timer_next_s = {TMR_W{1'b0}};
        state_next_s = ST_SHOW;
      end
      ST_TIMEOUT: begin
        timer_next_s = {TMR_W{1'b0}};
        state_next_s = ST_SHOW;
      end
      ST_SHOW: begin
        if (timer_r == HOLD_LAST) begin
          state_next_s = ST_IDLE;
          timer_next_s = {TMR_W{1'b0}};
        end else begin
          state_next_s = ST_SHOW;
          timer_next_s = timer_r + 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        timer_next_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // Strobe and Busy flops decoded from the next state, so each is a clean
  // register output aligned with the state it belongs to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      chk_run_r  <= 1'b0;
      chk_disp_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      chk_run_r  <= (state_next_s == ST_LAUNCH);
      chk_disp_r <= (state_next_s == ST_CAPTURE);
      busy_r     <= (state_next_s != ST_IDLE);
    end
  end

  // Verdict LEDs: cleared in LAUNCH, loaded in CAPTURE or TIMEOUT, held otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pass_led_r    <= 1'b0;
      fail_led_r    <= 1'b0;
      timeout_led_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LAUNCH: begin
          pass_led_r    <= 1'b0;
          fail_led_r    <= 1'b0;
          timeout_led_r <= 1'b0;
        end
        ST_CAPTURE: begin
          pass_led_r    <= chk.Chk_RSLT;
          fail_led_r    <= ~chk.Chk_RSLT;
          timeout_led_r <= 1'b0;
        end
        ST_TIMEOUT: begin
          pass_led_r    <= 1'b0;
          fail_led_r    <= 1'b1;
          timeout_led_r <= 1'b1;
        end
        default: begin
          pass_led_r    <= pass_led_r;
          fail_led_r    <= fail_led_r;
          timeout_led_r <= timeout_led_r;
        end
      endcase
    end
  end

`ifdef CHIP_TALLY_EN
  logic [7:0] pass_cnt_r;
  logic [7:0] fail_cnt_r;

  // Saturating pass/fail tallies; a timeout counts as a fail.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pass_cnt_r <= 8'd0;
      fail_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_CAPTURE: begin
          if (chk.Chk_RSLT) begin
            pass_cnt_r <= sat_inc8(pass_cnt_r);
          end else begin
            fail_cnt_r <= sat_inc8(fail_cnt_r);
          end
        end
        ST_TIMEOUT: begin
          fail_cnt_r <= sat_inc8(fail_cnt_r);
        end
        default: begin
          pass_cnt_r <= pass_cnt_r;
          fail_cnt_r <= fail_cnt_r;
        end
      endcase
    end
  end

  assign Pass_Count = pass_cnt_r;
  assign Fail_Count = fail_cnt_r;
`endif

  assign chk.Chk_Run       = chk_run_r;
  assign chk.Chk_DISP_RSLT = chk_disp_r;
  assign Busy              = busy_r;
  assign Pass_LED          = pass_led_r;
  assign Fail_LED          = fail_led_r;
  assign Timeout_LED       = timeout_led_r;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chip_test_sequencer
// Directed bench for chip_test_sequencer. Each run is planned as a timeline:
// from the cycle Start is raised, the bench works out in which cycles Chk_Run,
// Chk_DISP_RSLT and Busy must be high and from which cycle each verdict must
// show, and a compare process checks every cycle against that timeline.
// Literal expectations (pulse counts, Start-to-Run latency, LED values) are
// checked after each run.
// -----------------------------------------------------------------------------
module tb_chip_test_sequencer;
  localparam int T = 8;
  localparam int H = 4;
  localparam int N = 8192;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  logic Start = 1'b0;
  logic Busy, Pass_LED, Fail_LED, Timeout_LED;
`ifdef CHIP_TALLY_EN
  logic [7:0] Pass_Count, Fail_Count;
  int mp = 0;
  int mf = 0;
`endif

  chip_test_sequencer_if chk();

  chip_test_sequencer #(.TIMEOUT_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .chk         (chk),
    .Busy        (Busy),
    .Pass_LED    (Pass_LED),
    .Fail_LED    (Fail_LED),
    .Timeout_LED (Timeout_LED)
`ifdef CHIP_TALLY_EN
    ,
    .Pass_Count  (Pass_Count),
    .Fail_Count  (Fail_Count)
`endif
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Expected timeline, indexed by cycle number (cycle n follows the n-th rising edge).
  bit         e_busy [N];
  bit         e_run  [N];
  bit         e_disp [N];
  logic [2:0] e_led  [N];   // {Timeout, Fail, Pass}

  int   run_pulses = 0, run_high = 0, disp_pulses = 0, run_rise_cyc = 0;
  logic prev_run = 1'b0, prev_disp = 1'b0;
  logic [5:0] act_v, exp_v;
  int rs, rp0, dp0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Per-cycle compare against the planned timeline, sampled mid-cycle.
  always @(negedge Clk) begin
    if (cyc >= 1 && cyc < N) begin
      act_v = {Busy, chk.Chk_Run, chk.Chk_DISP_RSLT, Timeout_LED, Fail_LED, Pass_LED};
      exp_v = {e_busy[cyc], e_run[cyc], e_disp[cyc], e_led[cyc]};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_outputs cyc=%0d busy/run/disp/to/fail/pass actual=%b required=%b",
                 cyc, act_v, exp_v);
      end
    end
  end

  // Pulse monitor for the strobe outputs.
  always @(negedge Clk) begin
    if (chk.Chk_Run) run_high++;
    if (chk.Chk_Run && !prev_run) begin
      run_pulses++;
      run_rise_cyc = cyc;
    end
    if (chk.Chk_DISP_RSLT && !prev_disp) disp_pulses++;
    prev_run  = chk.Chk_Run;
    prev_disp = chk.Chk_DISP_RSLT;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One complete run. da = cycles after the Chk_Run cycle at which Done is
  // raised (0 = checker never answers); rep = also press Start during WAIT and SHOW.
  task automatic do_run(input int da, input bit r, input bit rep,
                        input logic [2:0] led_req, input int disp_req);
    int s, d, vc, idle, p0, h0, q0;
    logic [2:0] verdict;
    s = cyc; p0 = run_pulses; h0 = run_high; q0 = disp_pulses;
    if (da > 0) begin
      d = s + 3 + da;              // Done raised in this cycle, seen at the next edge
      vc = d + 2;                  // CAPTURE is d+1, verdict visible from d+2
      verdict = r ? 3'b001 : 3'b010;
    end else begin
      d = -100;
      vc = s + 5 + T;              // WAIT s+4..s+3+T, TIMEOUT s+4+T
      verdict = 3'b110;
    end
    idle = vc + H;
    for (int c = s + 3; c < idle; c++) e_busy[c] = 1'b1;
    e_run[s + 3] = 1'b1;
    if (da > 0) e_disp[d + 1] = 1'b1;
    for (int c = s + 4; c < N; c++) e_led[c] = (c >= vc) ? verdict : 3'b000;

    for (int c = s; c <= idle; c++) begin
      Start        = (c == s) || (rep && (c == s + 5 || c == vc));
      chk.Chk_Done = (c >= d) && (c < d + 2);
      chk.Chk_RSLT = r;
      step(1);
    end
    Start = 1'b0;
    chk.Chk_Done = 1'b0;

    check("run_pulse_count", run_pulses - p0, 1);
    check("run_pulse_width", run_high - h0, 1);
    check("start_to_run_latency", run_rise_cyc - s, 3);
    check("disp_pulse_count", disp_pulses - q0, disp_req);
    check("verdict_leds", {Timeout_LED, Fail_LED, Pass_LED}, led_req);
`ifdef CHIP_TALLY_EN
    if (da > 0 && r) mp++; else mf++;
    check("pass_count", Pass_Count, (mp > 255) ? 255 : mp);
    check("fail_count", Fail_Count, (mf > 255) ? 255 : mf);
`endif
  endtask

  initial begin
    chk.Chk_Done = 1'b0;
    chk.Chk_RSLT = 1'b0;
    for (int c = 0; c < N; c++) e_led[c] = 3'b000;
    #1 Reset_n = 1'b0;
    step(3);
    check("reset_outputs", {Busy, chk.Chk_Run, chk.Chk_DISP_RSLT, Timeout_LED, Fail_LED, Pass_LED}, 0);
    Reset_n = 1'b1;
    step(5);

    do_run(6, 1'b1, 1'b0, 3'b001, 1);   // pass
    step(3);
    do_run(6, 1'b0, 1'b0, 3'b010, 1);   // fail
    step(3);
    do_run(0, 1'b0, 1'b0, 3'b110, 0);   // hung checker
    step(3);
    do_run(T, 1'b1, 1'b0, 3'b001, 1);   // Done on the last WAIT cycle
    step(3);
    do_run(6, 1'b1, 1'b1, 3'b001, 1);   // extra presses while busy
    step(3);

    // Reset during WAIT with Start held high across reset release.
    rs = cyc; rp0 = run_pulses; dp0 = disp_pulses;
    e_run[rs + 3] = 1'b1;
    for (int c = rs + 3; c < rs + 9; c++) e_busy[c] = 1'b1;
    for (int c = rs + 4; c < N; c++) e_led[c] = 3'b000;
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    step(8);                            // cycle rs+9, WAIT cycle 6
    #2 Reset_n = 1'b0;
    Start = 1'b1;
    #1;
    check("async_reset_outputs", {Busy, chk.Chk_Run, chk.Chk_DISP_RSLT, Timeout_LED, Fail_LED, Pass_LED}, 0);
`ifdef CHIP_TALLY_EN
    check("async_reset_counts", {Pass_Count, Fail_Count}, 0);
    mp = 0;
    mf = 0;
`endif
    step(2);
    Reset_n = 1'b1;
    step(20);
    check("no_run_after_reset", run_pulses - rp0, 1);
    check("no_disp_after_reset", disp_pulses - dp0, 0);
    check("idle_after_reset", Busy, 0);
    Start = 1'b0;
    step(5);
    do_run(3, 1'b1, 1'b0, 3'b001, 1);   // normal run after reset
    step(3);

`ifdef CHIP_TALLY_EN
    for (int i = 0; i < 260; i++) begin
      do_run(1, 1'b1, 1'b0, 3'b001, 1);
      step(1);
    end
    check("pass_count_saturated", Pass_Count, 255);
    check("fail_count_zero", Fail_Count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/chip_test_sequencer.md
CHIP_TEST_SEQUENCER -- requirements
Module: chip_test_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: WAIT cycles allowed before a checker run is declared hung; legal range 2..65535.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles the SHOW state holds before a new Start is accepted; legal range 1..65535.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Start, input, 1 bit: asynchronous push-button level, active high.
REQ-007 SHALL have port Chk_Done, input, 1 bit: the chip checker's Done output.
REQ-008 SHALL have port Chk_RSLT, input, 1 bit: the chip checker's RSLT output, where 1 means pass.
REQ-009 SHALL have port Chk_Run, output, 1 bit: drives the checker's Run input.
REQ-010 SHALL have port Chk_DISP_RSLT, output, 1 bit: drives the checker's DISP_RSLT input.
REQ-011 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have ports Pass_LED, Fail_LED and Timeout_LED, outputs, 1 bit each: the latched verdict of the last run.
REQ-013 SHALL have ports Pass_Count and Fail_Count, outputs, 8 bits each: tally counters, present only under CHIP_TALLY_EN.

Function
REQ-014 SHALL synchronize Start through two flops before use; a run SHALL trigger only on a synchronized 0->1 edge.
REQ-015 SHALL implement the states IDLE, LAUNCH, WAIT, CAPTURE, TIMEOUT and SHOW.
REQ-016 IDLE SHALL move to LAUNCH on a Start edge; every other Start edge SHALL be ignored.
REQ-017 LAUNCH SHALL last exactly 1 cycle, SHALL drive Chk_Run=1, SHALL clear all three LEDs and the timer, and SHALL then move to WAIT.
REQ-018 WAIT SHALL increment the timer each cycle, SHALL move to CAPTURE when Chk_Done=1, and otherwise SHALL move to TIMEOUT when the timer reaches TIMEOUT_CYCLES-1.
REQ-019 If Chk_Done=1 on the same cycle the timer reaches its limit, Chk_Done SHALL win and the state SHALL move to CAPTURE.
REQ-020 CAPTURE SHALL last 1 cycle, SHALL drive Chk_DISP_RSLT=1, SHALL latch Pass_LED=Chk_RSLT and Fail_LED=~Chk_RSLT, and SHALL then move to SHOW.
REQ-021 TIMEOUT SHALL last 1 cycle, SHALL set Timeout_LED=1 and Fail_LED=1 with Pass_LED=0, SHALL keep Chk_DISP_RSLT=0, and SHALL then move to SHOW.
REQ-022 SHOW SHALL count HOLD_CYCLES cycles and SHALL then move to IDLE.
REQ-023 Chk_Run SHALL be 1 only in LAUNCH, and Chk_DISP_RSLT SHALL be 1 only in CAPTURE; both outputs SHALL be registered and glitch-free.
REQ-024 The LEDs SHALL hold their values from SHOW through IDLE until the next LAUNCH.
REQ-025 The timer width SHALL be $clog2 of the larger of TIMEOUT_CYCLES and HOLD_CYCLES, and the timer SHALL never wrap.
REQ-026 Latency SHALL be as follows: Chk_Run rises 3 cycles after the raw Start rise; a verdict is visible 2 cycles after Chk_Done is first seen high.

Reset
REQ-027 Reset_n=0 SHALL immediately force state IDLE, timer 0, synchronizer flops 0, all LEDs 0, Chk_Run=0, Chk_DISP_RSLT=0 and Busy=0.
REQ-028 Reset_n=0 SHALL also force Pass_Count=0 and Fail_Count=0 when CHIP_TALLY_EN is defined.
REQ-029 Reset asserted mid-run SHALL abort the run with no pulse emitted; release SHALL resume in IDLE and SHALL not trigger on a Start level that is already high.

Configuration
REQ-030 With the macro CHIP_TALLY_EN defined, CAPTURE SHALL increment Pass_Count on a pass, or Fail_Count on a fail.
REQ-031 With CHIP_TALLY_EN defined, TIMEOUT SHALL increment Fail_Count.
REQ-032 The tally counters SHALL saturate at 255.
REQ-033 With CHIP_TALLY_EN undefined, the Pass_Count and Fail_Count ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Pass case: Start pulse, model checker returns Done after 6 cycles with RSLT=1 -> Chk_Run is a single 1-cycle pulse, Chk_DISP_RSLT is a single pulse, Pass_LED=1, Fail_LED=0, Timeout_LED=0.
REQ-035 Fail case: Start pulse, model checker returns Done with RSLT=0 -> Fail_LED=1, Pass_LED=0, and Chk_DISP_RSLT pulses once.
REQ-036 Hung checker: Start pulse, Done never rises, TIMEOUT_CYCLES=8 -> TIMEOUT is entered on the 8th WAIT cycle, Timeout_LED=1, Fail_LED=1, and Chk_DISP_RSLT never pulses.
REQ-037 Tie case: Done rises on the same cycle the timer reaches TIMEOUT_CYCLES-1 -> CAPTURE is taken and Timeout_LED=0.
REQ-038 Busy and reset case: Start re-pulsed during WAIT and during SHOW produces no second Chk_Run; Reset_n asserted during WAIT clears all outputs asynchronously, and after release with Start held high no run occurs.
REQ-039 Saturation case (CHIP_TALLY_EN defined): 260 passing runs -> Pass_Count=255 and Fail_Count=0.
